// File: rtl/multi_strobe_gen_if.sv
// Control/status bundle for multi_strobe_gen: per-channel mode and trigger
// inputs, the shared period-config port, and the registered strobe/busy outputs.
interface multi_strobe_gen_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 28
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]  en_i;
    logic [N_CH-1:0]  oneshot_i;
    logic [N_CH-1:0]  start_i;
    logic             sync_i;
    logic             cfg_we_i;
    logic [CH_W-1:0]  cfg_ch_i;
    logic [CNT_W-1:0] cfg_period_i;
    logic [N_CH-1:0]  strobe_o;
    logic [N_CH-1:0]  busy_o;

    // Controller side: drives modes, triggers and config; observes strobes.
    modport master (
        output en_i, oneshot_i, start_i, sync_i, cfg_we_i, cfg_ch_i, cfg_period_i,
        input  strobe_o, busy_o
    );

    // Generator side.
    modport slave (
        input  en_i, oneshot_i, start_i, sync_i, cfg_we_i, cfg_ch_i, cfg_period_i,
        output strobe_o, busy_o
    );
endinterface

// File: rtl/multi_strobe_gen.sv
// Multi-channel programmable strobe generator. Each channel counts up to its
// programmed period and emits a one-cycle registered strobe, either forever
// (periodic) or once per trigger (one-shot, retriggerable). A global sync
// restarts every active channel's count.
module multi_strobe_gen #(
    parameter int N_CH            = 4,
    parameter int CNT_W           = 28,
    parameter int DEFAULT_FREQ_HZ = 60,
    parameter int BOARD_CLK_MHZ   = 50   // board clock frequency in MHz
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    multi_strobe_gen_if.slave bus
);
    localparam longint DEFAULT_PERIOD =
        longint'(BOARD_CLK_MHZ) * 64'sd1_000_000 / longint'(DEFAULT_FREQ_HZ);

    if (DEFAULT_PERIOD > ((longint'(1) << CNT_W) - 1)) begin : g_period_chk
        $error("multi_strobe_gen: DEFAULT_PERIOD %0d does not fit in CNT_W=%0d bits",
               DEFAULT_PERIOD, CNT_W);
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ARMED = 2'd2
    } state_e;

    logic [CNT_W-1:0] period_q [N_CH];
    logic [CNT_W-1:0] period_d [N_CH];
    logic [CNT_W-1:0] cnt_q    [N_CH];
    logic [CNT_W-1:0] cnt_d    [N_CH];
    state_e           st_q     [N_CH];
    state_e           st_d     [N_CH];
    logic [N_CH-1:0]  strobe_q, strobe_d;
    logic [N_CH-1:0]  busy_q,   busy_d;
    logic [CNT_W-1:0] last_cnt [N_CH];
    logic [N_CH-1:0]  term;

    // Terminal compare: count has reached max(period,1)-1; ">=" lets a shrunk
    // period terminate on the very next cycle instead of waiting for a wrap.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            last_cnt[k] = (period_q[k] == '0) ? '0 : period_q[k] - CNT_W'(1);
            term[k]     = (cnt_q[k] >= last_cnt[k]);
        end
    end

    // Next-state logic for every channel plus the shared config write port.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            // NOTE: every output of this block gets a default first so no path
            // leaves it unassigned, which would otherwise infer a latch.
            period_d[k] = period_q[k];
            cnt_d[k]    = cnt_q[k];
            st_d[k]     = st_q[k];
            strobe_d[k] = 1'b0;

            if (!bus.en_i[k]) begin
                st_d[k]  = IDLE;
                cnt_d[k] = '0;
            end else if (bus.sync_i && (st_q[k] != IDLE)) begin
                cnt_d[k] = '0;
            end else begin
                case (st_q[k])
                    IDLE: begin
                        cnt_d[k] = '0;
                        if (!bus.oneshot_i[k]) begin
                            st_d[k] = RUN;
                        end else if (bus.start_i[k]) begin
                            st_d[k] = ARMED;
                        end
                    end
                    RUN, ARMED: begin
                        if ((st_q[k] == ARMED) && bus.start_i[k]) begin
                            cnt_d[k] = '0;
                        end else if (term[k]) begin
                            cnt_d[k]    = '0;
                            strobe_d[k] = 1'b1;
                            st_d[k]     = bus.oneshot_i[k] ? IDLE : RUN;
                        end else begin
                            cnt_d[k] = cnt_q[k] + CNT_W'(1);
                        end
                    end
                    default: begin
                        st_d[k]  = IDLE;
                        cnt_d[k] = '0;
                    end
                endcase
            end

            // Out-of-range channel indices simply match no channel.
            if (bus.cfg_we_i && (int'(bus.cfg_ch_i) == k)) begin
                period_d[k] = bus.cfg_period_i;
            end

            busy_d[k] = (st_d[k] != IDLE);
        end
    end

    // State, counter, period and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            // NOTE: the period array is a handful of flops, not a RAM, so it is
            // reset like any other register to give every channel a known rate.
            for (int k = 0; k < N_CH; k++) begin
                period_q[k] <= CNT_W'(DEFAULT_PERIOD);
                cnt_q[k]    <= '0;
                st_q[k]     <= IDLE;
            end
            strobe_q <= '0;
            busy_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            period_q <= period_d;
            cnt_q    <= cnt_d;
            st_q     <= st_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.strobe_o = strobe_q;
    assign bus.busy_o   = busy_q;
endmodule
